moving_avg_ctrl: RTL

MOVING_AVG_CTRL -- requirements
Module: moving_avg_ctrl

---
 rtl/moving_avg_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/moving_avg_ctrl.sv
// 4-tap running-sum / average controller over 8-bit signed samples.
// One sample is processed per IDLE->ADD->SUB->OUT pass with a valid/ready handshake on each side.
module moving_avg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] sum,
  output logic [7:0] avg,
  output logic       full,
  output logic       busy
);

  localparam int unsigned DW   = 8;
  localparam int unsigned SW   = 10;
  localparam int unsigned TAPS = 4;
  localparam int unsigned CW   = 3;

  typedef enum logic [1:0] {IDLE, ADD, SUB, OUT} state_t;

  state_t        state;
  logic [SW-1:0] acc;
  logic [SW-1:0] acc_sub;
  logic [SW-1:0] x_ext;
  logic [SW-1:0] old_ext;
  logic [DW-1:0] hist [TAPS];
  logic [DW-1:0] x_new;
  logic [CW-1:0] count;

  // Sign-extended operands; the oldest tap leaves the window on SUB.
  assign x_ext   = {{(SW-DW){x_new[DW-1]}}, x_new};
  assign old_ext = {{(SW-DW){hist[TAPS-1][DW-1]}}, hist[TAPS-1]};
  assign acc_sub = acc - old_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      x_new     <= '0;
      count     <= '0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      avg       <= '0;
      full      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      x_new     <= '0;
      count     <= '0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      avg       <= '0;
      full      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_new    <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          // May wrap transiently; the following SUB brings it back in range.
          acc   <= acc + x_ext;
          state <= SUB;
        end
        SUB: begin
          acc <= acc_sub;
          for (int i = TAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
          hist[0] <= x_new;
          if (count != CW'(TAPS)) count <= count + CW'(1);
          sum       <= acc_sub;
          avg       <= acc_sub[SW-1:2];
          full      <= full | (count >= CW'(TAPS - 1));
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
